mem_1w2r_init: RTL and testbench
================================

# mem_1w2r_init

Single-write, dual-read register-file memory with registered read ports, optional write-to-read bypass, and a hardware initialisation sequencer that clears every entry after reset. It is the read-heavy counterpart of the team's dual-write single-read storage: one producer writes, and two independent consumers read. Typical consumers are two pipeline stages or two lookup engines. The sequencer guarantees known contents without relying on simulator or FPGA power-up values.

## Interface
- `ADDR_WIDTH`, default 4: address width; the array holds 2^ADDR_WIDTH entries.
- `DATA_WIDTH`, default 1: width of each entry.
- `INIT_VALUE`, default 0: value written to every entry by the init sequencer; truncated to DATA_WIDTH.
- `BYPASS`, default 1: when 1, a same-cycle write to the address being read is forwarded to the read data; when 0, the read returns the old contents.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_WIDTH  write address.
- `wdata`  in  DATA_WIDTH  write data.
- `re0`  in  1  read enable, port 0.
- `raddr0`  in  ADDR_WIDTH  read address, port 0.
- `rdata0`  out  DATA_WIDTH  registered read data, port 0.
- `rvalid0`  out  1  one-cycle pulse qualifying rdata0.
- `re1`, `raddr1`, `rdata1`, `rvalid1`: same as port 0, for port 1.
- `init_busy`  out  1  high while the init sequencer owns the array.

## Operation
- FSM has two states.
  - INIT: the sequencer writes INIT_VALUE to entry `init_cnt`, then increments the counter by 1 each cycle.
  - READY: normal operation.
- rst_n low forces the following asynchronously:
  - state=INIT, init_cnt=0, init_busy=1;
  - rdata0=rdata1=0, rvalid0=rvalid1=0.
  - The array itself is not reset; the sequencer clears it.
- INIT to READY transition:
  - occurs on the edge that writes entry 2^ADDR_WIDTH-1;
  - init_cnt is ADDR_WIDTH+1 bits wide, or compares against all-ones, so it never wraps silently;
  - init_busy is low from the following cycle.
- While in INIT:
  - `we` is ignored (the write is dropped, not queued);
  - `re0`/`re1` are ignored; rvalid stays 0 and rdata holds its value.
- In READY:
  - `we`=1 writes wdata to waddr at the clock edge.
  - `reN`=1 captures the array entry at raddrN into rdataN and sets rvalidN=1 on that edge.
  - `reN`=0 holds rdataN and clears rvalidN.
- Bypass applies when `BYPASS`=1, we=1, reN=1 and waddr==raddrN in the same cycle: rdataN takes wdata. With `BYPASS`=0, rdataN takes the pre-write contents.
- The two read ports are fully independent.
  - Both may read the same address in the same cycle; both receive identical data.
  - There are no read/read conflicts.
- Widths: addresses are used unmodified. Every value in 0..2^ADDR_WIDTH-1 is valid, so no out-of-range handling exists.

## Timing
- Read latency: 1 cycle. Address and re are sampled at edge N; rdata and rvalid are valid after edge N and until edge N+1.
- Write-to-read latency without bypass: a write at edge N is visible to a read sampled at edge N+1.
- Init duration: exactly 2^ADDR_WIDTH cycles after the first rising clk edge with rst_n high. init_busy is 1 for those cycles.
  - First accepted user access: cycle 2^ADDR_WIDTH, counting from the first edge after reset release as cycle 0.
- Reset asserted mid-INIT or mid-READY:
  - takes effect immediately, without waiting for a clock edge;
  - after release, INIT restarts from entry 0;
  - any partially cleared contents are fully re-cleared.
- rvalidN is never high for two consecutive cycles unless reN was high on both sampling edges.
- Outputs carry no combinational path from any input; all outputs are registered.

## Test plan
- Reset/init, ADDR_WIDTH=4, INIT_VALUE=0x5 (DATA_WIDTH=4): release rst_n, then poll.
  - init_busy is 1 for exactly 16 cycles, then 0.
  - Reading all 16 addresses on both ports returns 0x5 with rvalid pulses.
- Writes during INIT: issue we=1, waddr=3, wdata=0xA on cycle 2 of INIT, then read address 3 after init. Required result: 0x5, meaning the write was dropped. Also drive re0=1 during INIT; rvalid0 must stay 0.
- Basic read/write: write 0x1..0xF to addresses 1..15, then read them on port 0 while reading the reverse order on port 1. Every rdata equals its address on the port's own sequence, with 1-cycle latency.
- Collision: same cycle we=1, waddr=7, wdata=0xC, re0=re1=1, raddr0=raddr1=7, with entry 7 previously 0x2.
  - BYPASS=1: both rdata are 0xC.
  - BYPASS=0: both are 0x2; a read of 7 on the next cycle returns 0xC.
- Hold behaviour: after a read returns 0x9, deassert re0 for 5 cycles. rdata0 stays 0x9 and rvalid0 stays 0 throughout.
- Mid-operation reset: in READY, write 0xF everywhere, then pulse rst_n low between clock edges.
  - rdata and rvalid clear immediately.
  - init_busy is 1 again for 16 cycles.
  - All entries then read back as INIT_VALUE.

Source files
------------

// File: rtl/mem_1w2r_init_if.sv
// Write/read bus for mem_1w2r_init: one write port, two registered read ports
// and the init status flag.
interface mem_1w2r_init_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re0;
    logic [ADDR_WIDTH-1:0] raddr0;
    logic [DATA_WIDTH-1:0] rdata0;
    logic                  rvalid0;
    logic                  re1;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  rvalid1;
    logic                  init_busy;

    modport master (
        output we, waddr, wdata, re0, raddr0, re1, raddr1,
        input  rdata0, rvalid0, rdata1, rvalid1, init_busy
    );

    modport slave (
        input  we, waddr, wdata, re0, raddr0, re1, raddr1,
        output rdata0, rvalid0, rdata1, rvalid1, init_busy
    );
endinterface

// File: rtl/mem_1w2r_init.sv
// Single-write, dual-read register file with registered read ports, optional
// write-to-read bypass and a post-reset sequencer that clears every entry.
module mem_1w2r_init #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1,
    parameter int INIT_VALUE = 0,
    parameter int BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_1w2r_init_if.slave       bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] INIT_DATA = DATA_WIDTH'(INIT_VALUE);

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_busy_r;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata0_r, rdata1_r;
    logic                  rvalid0_r, rvalid1_r;

    // Forwarding picks up a same-cycle write so readers never see stale data.
    function automatic logic [DATA_WIDTH-1:0] rd_sel(input logic [ADDR_WIDTH-1:0] ra);
        if (BYPASS != 0 && bus.we && bus.waddr == ra)
            return bus.wdata;
        return mem[ra];
    endfunction

    // Init sequencer: the counter stops being consulted once it reaches all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            init_cnt    <= '0;
            init_busy_r <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (&init_cnt) begin
                        state       <= READY;
                        init_busy_r <= 1'b0;
                    end
                end
                READY: begin
                    state       <= READY;
                    init_busy_r <= 1'b0;
                end
                default: begin
                    state       <= INIT;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: the sequencer owns the write port until READY.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_cnt] <= INIT_DATA;
        else if (bus.we)
            mem[bus.waddr] <= bus.wdata;
    end

    // Registered read ports, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_r  <= '0;
            rdata1_r  <= '0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= (state == READY) && bus.re0;
            rvalid1_r <= (state == READY) && bus.re1;
            if (state == READY && bus.re0)
                rdata0_r <= rd_sel(bus.raddr0);
            if (state == READY && bus.re1)
                rdata1_r <= rd_sel(bus.raddr1);
        end
    end

    assign bus.rdata0    = rdata0_r;
    assign bus.rdata1    = rdata1_r;
    assign bus.rvalid0   = rvalid0_r;
    assign bus.rvalid1   = rvalid1_r;
    assign bus.init_busy = init_busy_r;
endmodule

// File: tb/tb_mem_1w2r_init.sv
// Scoreboard bench: one bypassing and one non-bypassing instance driven by the
// same random and directed traffic, checked against a behavioural model.
module tb_mem_1w2r_init;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int N  = 16;
    localparam logic [DW-1:0] IV = 4'h5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          we = 1'b0, re0 = 1'b0, re1 = 1'b0;
    logic [AW-1:0] waddr = '0, raddr0 = '0, raddr1 = '0;
    logic [DW-1:0] wdata = '0;

    mem_1w2r_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    mem_1w2r_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    assign ifa.we = we;  assign ifa.waddr = waddr;   assign ifa.wdata = wdata;
    assign ifa.re0 = re0; assign ifa.raddr0 = raddr0; assign ifa.re1 = re1; assign ifa.raddr1 = raddr1;
    assign ifb.we = we;  assign ifb.waddr = waddr;   assign ifb.wdata = wdata;
    assign ifb.re0 = re0; assign ifb.raddr0 = raddr0; assign ifb.re1 = re1; assign ifb.raddr1 = raddr1;

    mem_1w2r_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(5), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mem_1w2r_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(5), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct packed {
        logic          busy;
        logic          v0, v1;
        logic [DW-1:0] d0a, d1a, d0b, d1b;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: after reset the contents are simply INIT_VALUE and the
    // block is deaf for N edges.
    logic [DW-1:0] mem_m [N];
    int            busy_left;
    logic [DW-1:0] l0a, l1a, l0b, l1b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mem_m[i] = IV;
        busy_left = N;
        l0a = '0; l1a = '0; l0b = '0; l1b = '0;
    endtask

    task automatic model_edge();
        exp_t e;
        e.v0 = 1'b0;
        e.v1 = 1'b0;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (re0) begin
                l0a = (we && waddr == raddr0) ? wdata : mem_m[raddr0];
                l0b = mem_m[raddr0];
            end
            if (re1) begin
                l1a = (we && waddr == raddr1) ? wdata : mem_m[raddr1];
                l1b = mem_m[raddr1];
            end
            e.v0 = re0;
            e.v1 = re1;
            if (we) mem_m[waddr] = wdata;
        end
        e.busy = (busy_left > 0);
        e.d0a = l0a; e.d1a = l1a; e.d0b = l0b; e.d1b = l1b;
        sb.push_back(e);
    endtask

    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic [AW-1:0] a1);
        we = w; waddr = wa; wdata = wd;
        re0 = r0; raddr0 = a0; re1 = r1; raddr1 = a1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_step();
        step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
             1'($urandom), 4'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata0_a"}, ifa.rdata0, 0);   chk({tag, "_rdata1_a"}, ifa.rdata1, 0);
        chk({tag, "_rvalid0_a"}, ifa.rvalid0, 0); chk({tag, "_rvalid1_a"}, ifa.rvalid1, 0);
        chk({tag, "_busy_a"}, ifa.init_busy, 1);
        chk({tag, "_rdata0_b"}, ifb.rdata0, 0);   chk({tag, "_rvalid0_b"}, ifb.rvalid0, 0);
        chk({tag, "_busy_b"}, ifb.init_busy, 1);
    endtask

    // Monitor: every modelled edge has one entry, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("busy_a", ifa.init_busy, e.busy);   chk("busy_b", ifb.init_busy, e.busy);
            chk("rvalid0_a", ifa.rvalid0, e.v0);    chk("rvalid1_a", ifa.rvalid1, e.v1);
            chk("rvalid0_b", ifb.rvalid0, e.v0);    chk("rvalid1_b", ifb.rvalid1, e.v1);
            chk("rdata0_a", ifa.rdata0, e.d0a);     chk("rdata1_a", ifa.rdata1, e.d1a);
            chk("rdata0_b", ifb.rdata0, e.d0b);     chk("rdata1_b", ifb.rdata1, e.d1b);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // INIT: reads and a write at cycle 2 must all be ignored.
        for (int c = 0; c < N; c++)
            step(c == 2, 4'd3, 4'hA, 1'b1, 4'(c), 1'b1, 4'(N - 1 - c));

        for (int i = 0; i < N; i++)
            step(1'b0, '0, '0, 1'b1, 4'(i), 1'b1, 4'(N - 1 - i));

        for (int i = 1; i < N; i++)
            step(1'b1, 4'(i), 4'(i), 1'b0, '0, 1'b0, '0);
        for (int i = 1; i < N; i++)
            step(1'b0, '0, '0, 1'b1, 4'(i), 1'b1, 4'(N - i));

        // Write/read collision on entry 7 previously holding 0x2.
        step(1'b1, 4'd7, 4'h2, 1'b0, '0, 1'b0, '0);
        step(1'b1, 4'd7, 4'hC, 1'b1, 4'd7, 1'b1, 4'd7);
        step(1'b0, '0, '0, 1'b1, 4'd7, 1'b1, 4'd7);

        // Hold: read 0x9 then idle port 0 for five cycles.
        step(1'b1, 4'd9, 4'h9, 1'b0, '0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 4'd9, 1'b0, '0);
        for (int i = 0; i < 5; i++)
            step(1'b0, '0, '0, 1'b0, 4'd9, 1'b0, '0);

        for (int i = 0; i < 300; i++)
            rand_step();

        // Fill with 0xF, read once, then reset between clock edges.
        for (int i = 0; i < N; i++)
            step(1'b1, 4'(i), 4'hF, 1'b0, '0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 4'd4, 1'b1, 4'd11);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        for (int c = 0; c < N; c++)
            rand_step();
        for (int i = 0; i < N; i++)
            step(1'b0, '0, '0, 1'b1, 4'(i), 1'b1, 4'(N - 1 - i));

        for (int i = 0; i < 50; i++)
            rand_step();

        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
